// File: rtl/rx_sample_framer.sv
// Frames DDC {I,Q} samples into tlast-delimited AXI-stream packets; RX_FRAMER_HDR_EN adds a {seq,spp} header per packet.
// Latency: strobe in cycle N -> o_tvalid in cycle N+2 (input register, then FIFO write).
// Backpressure: o_tready stalls the FIFO; samples arriving while it is full are dropped and set sticky overflow.

// Generic first-word-fall-through FIFO with registered pointers.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push is ignored when full (pre-pop), pop is ignored when empty.
module rx_framer_fifo #(
    parameter int W  = 34,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
    output logic [W-1:0]  pop_dat_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);
    logic [W-1:0] mem_q [2**AW];
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic         do_push, do_pop;

    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end
endmodule

module rx_sample_framer #(
    parameter int          BASE        = 0,
    parameter int          FIFO_SIZE   = 5,
    parameter logic [15:0] DEFAULT_SPP = 16'd364
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 set_stb,
    input  logic [7:0]           set_addr,
    input  logic [31:0]          set_data,
    input  logic [31:0]          sample,
    input  logic                 strobe,
    input  logic                 run,
    output logic [31:0]          o_tdata,
    output logic                 o_tlast,
    output logic                 o_tuser,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    output logic                 overflow,
    output logic [FIFO_SIZE:0]   occupancy
);
    localparam logic [7:0]  ADDR_SPP = 8'(BASE);
    localparam logic [7:0]  ADDR_OVF = 8'(BASE + 1);
    localparam logic [15:0] SPP_RST  = (DEFAULT_SPP == 16'd0) ? 16'd1 : DEFAULT_SPP;

    typedef enum logic [1:0] {IN_IDLE, IN_RUN, IN_EOB_PEND} in_state_t;

    in_state_t   in_state_q, in_state_d;
    logic [31:0] sample_q;
    logic        strobe_q, run_q, run_d_q;
    logic [15:0] spp_q, spp_pend_q, spp_eff;
    logic [15:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        sample_evt, is_last;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [33:0] fifo_wdat, fifo_head;
    logic        unused_set_hi;

    assign unused_set_hi = ^set_data[31:16];

    // Inputs are registered once; all framing decisions work on the registered copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
            strobe_q <= 1'b0;
            run_q    <= 1'b0;
            run_d_q  <= 1'b0;
        end else if (clr) begin
            sample_q <= '0;
            strobe_q <= 1'b0;
            run_q    <= 1'b0;
            run_d_q  <= 1'b0;
        end else begin
            sample_q <= sample;
            strobe_q <= strobe;
            run_q    <= run;
            run_d_q  <= run_q;
        end
    end

    // A written spp only becomes active on a packet boundary, so packets never change length mid-flight.
    assign spp_eff = (cnt_q == 16'd0) ? spp_pend_q : spp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spp_pend_q <= SPP_RST;
            spp_q      <= SPP_RST;
        end else begin
            if (set_stb && set_addr == ADDR_SPP) begin
                spp_pend_q <= (set_data[15:0] == 16'd0) ? 16'd1 : set_data[15:0];
            end
            spp_q <= spp_eff;
        end
    end

    assign sample_evt = strobe_q && run_q;
    assign is_last    = (cnt_q == spp_eff - 16'd1);

    always_comb begin
        in_state_d = in_state_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        fifo_push  = 1'b0;
        fifo_wdat  = '0;
        case (in_state_q)
            IN_IDLE: if (run_q) in_state_d = IN_RUN;
            IN_RUN: begin
                if (run_d_q && !run_q) begin
                    in_state_d = (cnt_q == 16'd0) ? IN_IDLE : IN_EOB_PEND;
                end
            end
            IN_EOB_PEND: begin
                if (!fifo_full) begin
                    fifo_push  = 1'b1;
                    fifo_wdat  = {1'b1, 1'b1, 32'h0};
                    cnt_d      = 16'd0;
                    in_state_d = IN_IDLE;
                end
            end
            default: in_state_d = IN_IDLE;
        endcase
        if (set_stb && set_addr == ADDR_OVF) begin
            ovf_d = 1'b0;
        end
        // Ordered after the clear so a drop in the same cycle as a clear-write keeps the flag set.
        if (sample_evt) begin
            if (in_state_q == IN_EOB_PEND || fifo_full) begin
                ovf_d = 1'b1;
            end else begin
                fifo_push = 1'b1;
                fifo_wdat = {1'b0, is_last, sample_q};
                cnt_d     = is_last ? 16'd0 : cnt_q + 16'd1;
            end
        end
        if (clr) begin
            in_state_d = IN_IDLE;
            cnt_d      = 16'd0;
            ovf_d      = 1'b0;
            fifo_push  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_state_q <= IN_IDLE;
            cnt_q      <= 16'd0;
            ovf_q      <= 1'b0;
        end else begin
            in_state_q <= in_state_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign overflow = ovf_q;

    rx_framer_fifo #(.W(34), .AW(FIFO_SIZE)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr),
        .push_i     (fifo_push),
        .push_dat_i (fifo_wdat),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (occupancy)
    );

`ifdef RX_FRAMER_HDR_EN
    typedef enum logic {OUT_HDR, OUT_BODY} out_state_t;

    out_state_t  out_state_q, out_state_d;
    logic [15:0] seq_q, seq_d;

    always_comb begin
        out_state_d = out_state_q;
        seq_d       = seq_q;
        o_tvalid    = !fifo_empty && !clr;
        o_tdata     = '0;
        o_tlast     = 1'b0;
        o_tuser     = 1'b0;
        fifo_pop    = 1'b0;
        case (out_state_q)
            OUT_HDR: begin
                // The header only waits for body data to exist; it never consumes a FIFO entry.
                if (o_tvalid) o_tdata = {seq_q, spp_q};
                if (o_tvalid && o_tready) out_state_d = OUT_BODY;
            end
            default: begin
                if (o_tvalid) begin
                    o_tdata = fifo_head[31:0];
                    o_tlast = fifo_head[32];
                    o_tuser = fifo_head[33];
                end
                fifo_pop = o_tvalid && o_tready;
                if (fifo_pop && fifo_head[32]) begin
                    out_state_d = OUT_HDR;
                    seq_d       = seq_q + 16'd1;
                end
            end
        endcase
        if (clr) begin
            out_state_d = OUT_HDR;
            seq_d       = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state_q <= OUT_HDR;
            seq_q       <= 16'd0;
        end else begin
            out_state_q <= out_state_d;
            seq_q       <= seq_d;
        end
    end
`else
    assign o_tvalid = !fifo_empty && !clr;
    assign o_tdata  = o_tvalid ? fifo_head[31:0] : 32'h0;
    assign o_tlast  = o_tvalid && fifo_head[32];
    assign o_tuser  = o_tvalid && fifo_head[33];
    assign fifo_pop = o_tvalid && o_tready;
`endif
endmodule
